// File: rtl/znc_branch.sv
// Conditional-branch sequencer: PC plus ZNC flag register; a taken branch lands on pc one cycle after accept.
// Backpressure: ins_ready drops for the single FLUSH cycle after a taken branch and permanently in HALT.
module znc_branch #(
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter logic [3:0]  BR_OP    = 4'hB
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        flag_we,
   input  logic [2:0]  flag_in,
   input  logic [15:0] ins,
   input  logic        ins_valid,
   output logic        ins_ready,
   output logic [15:0] pc,
   output logic [2:0]  znc,
   output logic        redirect,
   output logic        halted,
   output logic [7:0]  taken_cnt
);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      FLUSH = 2'd1,
      HALT  = 2'd2
   } state_t;

   typedef struct packed {
      logic       is_halt;
      logic       is_br;
      logic [2:0] mask;
      logic       pol;
      logic [7:0] off;
   } dec_t;

   state_t      state, state_nxt;
   logic [15:0] pc_nxt;
   logic [7:0]  cnt_nxt;
   dec_t        dec;
   logic        accept;
   logic [2:0]  flags_eff;
   logic        cond;
   logic        taken;
   logic [15:0] off_ext;

   // All-ones is halt even if BR_OP happens to be 4'hF.
   always_comb begin
      dec         = '0;
      dec.is_halt = (ins == 16'hFFFF);
      dec.is_br   = (ins[15:12] == BR_OP) && !dec.is_halt;
      dec.mask    = ins[11:9];
      dec.pol     = ins[8];
      dec.off     = ins[7:0];
   end

   assign ins_ready = (state == RUN);
   assign accept    = ins_valid && ins_ready;
   assign flags_eff = flag_we ? flag_in : znc;
   assign cond      = (dec.mask == 3'b000) ? 1'b1
                                           : (((flags_eff & dec.mask) != 3'b000) ^ dec.pol);
   assign taken     = accept && dec.is_br && cond;
   assign off_ext   = {{8{dec.off[7]}}, dec.off};

   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      cnt_nxt   = taken_cnt;
      case (state)
         RUN: begin
            if (accept) begin
               if (dec.is_halt) begin
                  state_nxt = HALT;
               end else if (taken) begin
                  pc_nxt    = pc + off_ext;
                  state_nxt = FLUSH;
                  cnt_nxt   = (taken_cnt == 8'hFF) ? taken_cnt : taken_cnt + 8'd1;
               end else begin
                  pc_nxt = pc + 16'd1;
               end
            end
         end
         FLUSH:   state_nxt = RUN;
         HALT:    state_nxt = HALT;
         default: state_nxt = RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= RUN;
         pc        <= RESET_PC;
         znc       <= 3'b000;
         taken_cnt <= 8'd0;
      end else begin
         state     <= state_nxt;
         pc        <= pc_nxt;
         taken_cnt <= cnt_nxt;
         if (flag_we) begin
            znc <= flag_in;
         end
      end
   end

   assign redirect = (state == FLUSH);
   assign halted   = (state == HALT);

endmodule

// File: doc/znc_branch.md
ZNC_BRANCH -- requirements
Module: znc_branch

Interface
REQ-001 SHALL provide parameter RESET_PC, default 16'h0000, the PC value loaded on reset.
REQ-002 SHALL provide parameter BR_OP, default 4'hB, the ins[15:12] opcode that identifies a conditional branch.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port flag_we  input  1  write-enable for the flag register.
REQ-006 SHALL have port flag_in  input  3  new ZNC value from the flag stage; bit 2 = Z, bit 1 = N, bit 0 = C.
REQ-007 SHALL have port ins  input  16  the instruction word.
REQ-008 SHALL have port ins_valid  input  1  ins is presented this cycle.
REQ-009 SHALL have port ins_ready  output  1  the block accepts ins this cycle.
REQ-010 SHALL have port pc  output  16  the current program counter, registered.
REQ-011 SHALL have port znc  output  3  the registered flag state, fed back to the flag stage.
REQ-012 SHALL have port redirect  output  1  one-cycle pulse, asserted in the cycle after a taken branch is accepted.
REQ-013 SHALL have port halted  output  1  the block is in HALT.
REQ-014 SHALL have port taken_cnt  output  8  the count of taken branches.

Function
REQ-015 SHALL implement the state machine RUN, FLUSH, HALT, with ins_ready = 1 only in RUN.
REQ-016 SHALL accept an instruction only when ins_valid and ins_ready are both 1; when no instruction is accepted, pc SHALL hold.
REQ-017 SHALL decode the branch fields as follows: ins[15:12] == BR_OP marks a branch; ins[11:9] is the mask M; ins[8] is the polarity P; ins[7:0] is the signed offset.
REQ-018 SHALL evaluate the condition as cond = (M == 0) ? 1 : ((F & M) != 0) XOR P, where F is the effective flag value.
REQ-019 SHALL set F = flag_in when flag_we = 1 in the same cycle as the accept (bypass); otherwise F = znc.
REQ-020 SHALL update pc on an accepted non-branch, or on a branch that is not taken, to pc + 1 mod 2^16, and SHALL stay in RUN.
REQ-021 SHALL, on an accepted taken branch, load pc with pc + sign_extend(ins[7:0]) mod 2^16, go to FLUSH, and increment taken_cnt.
REQ-022 SHALL hold FLUSH for exactly one cycle with ins_ready = 0, assert redirect during that cycle, and then return to RUN.
REQ-023 SHALL, on an accepted ins == 16'hFFFF, enter HALT with pc unchanged; HALT SHALL be left only by reset.
REQ-024 SHALL decode 16'hFFFF as halt, taking priority over the branch decode.
REQ-025 SHALL load znc <= flag_in on every cycle with flag_we = 1, in any state including FLUSH and HALT.
REQ-026 SHALL saturate taken_cnt at 8'hFF with no wrap.
REQ-027 SHALL wrap pc arithmetic modulo 2^16 in both directions, for example 16'hFFFF + 1 = 16'h0000 and 16'h0000 - 1 = 16'hFFFF.
REQ-028 SHALL have a branch latency of one cycle: the target appears on pc in the cycle after the accept, and the next accept is possible two cycles after the branch accept.

Reset
REQ-029 SHALL, on a rising edge with rst_n = 0, set pc = RESET_PC, znc = 3'b000, state = RUN, redirect = 0, halted = 0, and taken_cnt = 0.
REQ-030 SHALL let reset override all other inputs, including flag_we and an accept in the same cycle, and abort a FLUSH or HALT in progress.
REQ-031 SHALL assert ins_ready = 1 in the first cycle after rst_n returns to 1.

Verification
REQ-032 SHALL cover: reset, then 3 accepted non-branch instructions -> pc = 0, 1, 2, 3, with redirect = 0 throughout.
REQ-033 SHALL cover: znc = 3'b100 (Z set), ins = 16'hB804 (M = 100, P = 0, offset +4) at pc = 5 -> pc = 9, FLUSH for one cycle with redirect = 1 and ins_ready = 0, taken_cnt = 1.
REQ-034 SHALL cover: znc = 3'b000, with flag_we = 1 and flag_in = 3'b100 in the same cycle as ins = 16'hB8FE at pc = 16'h0001 -> the bypass makes the branch taken, and pc = 16'hFFFF.
REQ-035 SHALL cover: ins = 16'hB904 (P = 1) with Z set -> not taken, pc + 1; ins = 16'hB000 (M = 0) -> always taken, pc unchanged (offset 0), and FLUSH is still entered.
REQ-036 SHALL cover: 300 taken branches -> taken_cnt = 8'hFF; then ins = 16'hFFFF -> halted = 1, ins_ready = 0, pc frozen; then rst_n = 0 for one edge -> all reset values restored.
